route_select_allocator: RTL and testbench

- Consumer side of the odd-even route computation. Per input port, it latches the candidate output directions and picks the candidate with the most downstream credits.
- Arbitrates round-robin among inputs competing for each output port, then holds the granted input→output path until the tail flit departs.
- Tracks per-output downstream credits. Sits between the routing unit and the crossbar in each router.

---
 rtl/route_select_allocator.sv | 166 ++++++++++++++++
 tb/tb_route_select_allocator.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/route_select_allocator.sv
// rtl/route_select_allocator.sv - per-input route selection, round-robin output allocation and credit tracking
module route_select_allocator #(
    parameter int N      = 5,
    parameter int DEPTH  = 4,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N-1:0]           i_select_neighbor,
    input  logic [N-1:0]           i_eject,
    input  logic [N-1:0][1:0]      i_avail_count,
    input  logic [N-1:0][0:1][1:0] i_avail_dir,
    input  logic [N-1:0]           i_flit_valid,
    input  logic [N-1:0]           i_flit_tail,
    input  logic [N-1:0]           i_credit_return,
    output logic [N-1:0]           o_grant_valid,
    output logic [N-1:0][2:0]      o_grant_port,
    output logic [N-1:0]           o_flit_send,
    output logic [N-1:0]           o_out_busy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REQ    = 2'd1,
        S_ACTIVE = 2'd2
    } state_t;

    state_t state_q [N];
    state_t state_d [N];

    logic [N-1:0]           lat_eject;
    logic [N-1:0][1:0]      lat_count;
    logic [N-1:0][0:1][1:0] lat_dir;
    logic [N-1:0][2:0]      gport_q;
    logic [N-1:0][CW-1:0]   credit_q;
    logic [N-1:0][2:0]      rr_ptr;

    logic [N-1:0][2:0] cand0;
    logic [N-1:0][2:0] cand1;
    logic [N-1:0][2:0] target;
    logic [N-1:0]      req;
    logic [N-1:0]      grant;
    logic [N-1:0]      send;
    logic [N-1:0]      out_busy;
    logic [N-1:0]      dec;
    logic [N-1:0]      win_valid;
    logic [N-1:0][2:0] win_idx;

    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (reset) state_q[i] <= S_IDLE;
            else       state_q[i] <= state_d[i];
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            state_d[i] = state_q[i];
            case (state_q[i])
                S_IDLE:   if (i_select_neighbor[i])          state_d[i] = S_REQ;
                S_REQ:    if (grant[i])                      state_d[i] = S_ACTIVE;
                S_ACTIVE: if (send[i] && i_flit_tail[i])     state_d[i] = S_IDLE;
                default:                                     state_d[i] = S_IDLE;
            endcase
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            o_grant_valid[i] = (state_q[i] == S_ACTIVE);
            o_grant_port[i]  = (state_q[i] == S_ACTIVE) ? gport_q[i] : 3'd0;
        end
        o_flit_send = send;
        o_out_busy  = out_busy;
    end

    // An output is busy exactly while some ACTIVE input holds it, so a tail frees it on the next edge.
    always_comb begin
        out_busy = '0;
        send     = '0;
        dec      = '0;
        for (int i = 0; i < N; i++) begin
            if (state_q[i] == S_ACTIVE) begin
                out_busy[gport_q[i]] = 1'b1;
                send[i] = i_flit_valid[i] && (credit_q[gport_q[i]] != '0);
                if (send[i]) dec[gport_q[i]] = 1'b1;
            end
        end
    end

    // Target is re-evaluated every REQ cycle against live credit counts; ties favour the first candidate.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            cand0[i] = 3'(lat_dir[i][0]) + 3'd1;
            cand1[i] = 3'(lat_dir[i][1]) + 3'd1;
            if (lat_eject[i])
                target[i] = 3'd0;
            else if (lat_count[i] == 2'd2)
                target[i] = (credit_q[cand1[i]] > credit_q[cand0[i]]) ? cand1[i] : cand0[i];
            else
                target[i] = cand0[i];
            req[i] = (state_q[i] == S_REQ) && !out_busy[target[i]];
        end
    end

    always_comb begin
        int idx;
        idx       = 0;
        grant     = '0;
        win_valid = '0;
        win_idx   = '0;
        for (int j = 0; j < N; j++) begin
            for (int k = 1; k <= N; k++) begin
                idx = (int'(rr_ptr[j]) + k) % N;
                if (!win_valid[j] && req[idx] && (target[idx] == 3'(j))) begin
                    win_valid[j] = 1'b1;
                    win_idx[j]   = 3'(idx);
                    grant[idx]   = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lat_eject <= '0;
            lat_count <= '0;
            lat_dir   <= '0;
            gport_q   <= '0;
            rr_ptr    <= '0;
            for (int j = 0; j < N; j++) credit_q[j] <= CW'(DEPTH);
        end else begin
            for (int i = 0; i < N; i++) begin
                if (state_q[i] == S_IDLE && i_select_neighbor[i]) begin
                    lat_eject[i] <= i_eject[i];
                    lat_count[i] <= i_avail_count[i];
                    lat_dir[i]   <= i_avail_dir[i];
                end
                if (grant[i]) gport_q[i] <= target[i];
            end
            for (int j = 0; j < N; j++) begin
                if (win_valid[j]) rr_ptr[j] <= win_idx[j];
                if (dec[j] && !i_credit_return[j])
                    credit_q[j] <= credit_q[j] - CW'(1);
                else if (i_credit_return[j] && !dec[j] && credit_q[j] != CW'(DEPTH))
                    credit_q[j] <= credit_q[j] + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < N; i++) begin
                if (state_q[i] == S_REQ && !lat_eject[i])
                    assert (lat_count[i] == 2'd1 || lat_count[i] == 2'd2)
                    else $warning("illegal candidate count on input %0d", i);
            end
            for (int j = 0; j < N; j++) begin
                if (i_credit_return[j] && !dec[j])
                    assert (credit_q[j] != CW'(DEPTH))
                    else $warning("credit return saturated on output %0d", j);
            end
        end
    end

endmodule

// File: tb/tb_route_select_allocator.sv
// tb/tb_route_select_allocator.sv - directed table, corner sequences and randomized model check for route_select_allocator
module tb_route_select_allocator;

    localparam int N     = 5;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   reset;
    logic [N-1:0]           sel, ej, fv, tl, cr;
    logic [N-1:0][1:0]      cnt;
    logic [N-1:0][0:1][1:0] dir;
    logic [N-1:0]           gv, snd, busy;
    logic [N-1:0][2:0]      gp;

    int checks = 0;
    int errors = 0;

    route_select_allocator #(.N(N), .DEPTH(DEPTH)) dut (
        .clk               (clk),
        .reset             (reset),
        .i_select_neighbor (sel),
        .i_eject           (ej),
        .i_avail_count     (cnt),
        .i_avail_dir       (dir),
        .i_flit_valid      (fv),
        .i_flit_tail       (tl),
        .i_credit_return   (cr),
        .o_grant_valid     (gv),
        .o_grant_port      (gp),
        .o_flit_send       (snd),
        .o_out_busy        (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        sel = '0; ej = '0; cnt = '0; dir = '0; fv = '0; tl = '0; cr = '0;
    endtask

    function automatic logic [31:0] gp_masked();
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < N; i++) if (gv[i]) v[i*3 +: 3] = gp[i];
        return v;
    endfunction

    // Reference model: owner of each output, pending requesters, credits and pointers
    int m_owner [N];
    bit m_wait  [N];
    bit m_ej    [N];
    int m_cnt   [N];
    int m_d0    [N];
    int m_d1    [N];
    int m_cred  [N];
    int m_ptr   [N];

    task automatic model_reset();
        for (int j = 0; j < N; j++) begin
            m_owner[j] = -1; m_wait[j] = 0; m_ej[j] = 0; m_cnt[j] = 1;
            m_d0[j] = 0; m_d1[j] = 0; m_cred[j] = DEPTH; m_ptr[j] = 0;
        end
    endtask

    function automatic int m_port_of(input int i);
        for (int j = 0; j < N; j++) if (m_owner[j] == i) return j;
        return -1;
    endfunction

    function automatic int m_target(input int i);
        int p0, p1;
        p0 = m_d0[i] + 1;
        p1 = m_d1[i] + 1;
        if (m_ej[i]) return 0;
        if (m_cnt[i] == 2) return (m_cred[p1] > m_cred[p0]) ? p1 : p0;
        return p0;
    endfunction

    function automatic bit m_sends(input int i);
        int p;
        p = m_port_of(i);
        return (p >= 0) && fv[i] && (m_cred[p] > 0);
    endfunction

    task automatic model_check();
        logic [31:0] e_gv, e_gp, e_snd, e_busy;
        int p;
        e_gv = '0; e_gp = '0; e_snd = '0; e_busy = '0;
        for (int i = 0; i < N; i++) begin
            p = m_port_of(i);
            if (p >= 0) begin
                e_gv[i] = 1'b1;
                e_gp[i*3 +: 3] = 3'(p);
            end
            e_snd[i]  = m_sends(i);
            e_busy[i] = (m_owner[i] >= 0);
        end
        chk("rand_grant_valid", 32'(gv), e_gv);
        chk("rand_grant_port", gp_masked(), e_gp);
        chk("rand_flit_send", 32'(snd), e_snd);
        chk("rand_out_busy", 32'(busy), e_busy);
    endtask

    task automatic model_step();
        int  no       [N];
        int  pre_port [N];
        bit  sent     [N];
        bit  pre_wait [N];
        int  idx;
        bit  d;
        for (int i = 0; i < N; i++) begin
            pre_port[i] = m_port_of(i);
            sent[i]     = m_sends(i);
            pre_wait[i] = m_wait[i];
            no[i]       = m_owner[i];
        end
        for (int j = 0; j < N; j++) begin
            if (m_owner[j] < 0) begin
                for (int k = 1; k <= N; k++) begin
                    idx = (m_ptr[j] + k) % N;
                    if (m_wait[idx] && m_target(idx) == j) begin
                        no[j] = idx; m_ptr[j] = idx; m_wait[idx] = 0;
                        break;
                    end
                end
            end
        end
        for (int i = 0; i < N; i++)
            if (pre_port[i] >= 0 && sent[i] && tl[i]) no[pre_port[i]] = -1;
        for (int j = 0; j < N; j++) begin
            d = 0;
            for (int i = 0; i < N; i++) if (sent[i] && pre_port[i] == j) d = 1;
            if (d && !cr[j]) m_cred[j]--;
            else if (cr[j] && !d && m_cred[j] < DEPTH) m_cred[j]++;
        end
        for (int i = 0; i < N; i++) begin
            if (!pre_wait[i] && pre_port[i] < 0 && sel[i]) begin
                m_wait[i] = 1; m_ej[i] = ej[i]; m_cnt[i] = int'(cnt[i]);
                m_d0[i] = int'(dir[i][0]); m_d1[i] = int'(dir[i][1]);
            end
        end
        for (int j = 0; j < N; j++) m_owner[j] = no[j];
    endtask

    typedef struct {
        int         inp;
        bit         s;
        bit         e;
        int         c;
        int         d0;
        int         d1;
        bit         v;
        bit         t;
        logic [4:0] r;
        bit         egv;
        int         egp;
        bit         esnd;
        logic [4:0] ebusy;
    } row_t;

    row_t tbl[$];

    function automatic row_t row_strobe(int inp, bit e, int c, int d0, int d1, bit v, bit t);
        row_t x;
        x = '{inp, 1'b1, e, c, d0, d1, v, t, 5'b0, 1'b0, 0, 1'b0, 5'b0};
        return x;
    endfunction

    function automatic row_t row_idle(int inp, logic [4:0] r);
        row_t x;
        x = '{inp, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0, r, 1'b0, 0, 1'b0, 5'b0};
        return x;
    endfunction

    function automatic row_t row_act(int inp, bit v, bit t, logic [4:0] r, int egp, bit esnd);
        row_t x;
        x = '{inp, 1'b0, 1'b0, 0, 0, 0, v, t, r, 1'b1, egp, esnd, 5'(1 << egp)};
        return x;
    endfunction

    task automatic run_table();
        row_t r;
        for (int k = 0; k < tbl.size(); k++) begin
            r = tbl[k];
            clear_inputs();
            sel[r.inp] = r.s; ej[r.inp] = r.e; cnt[r.inp] = 2'(r.c);
            dir[r.inp][0] = 2'(r.d0); dir[r.inp][1] = 2'(r.d1);
            fv[r.inp] = r.v; tl[r.inp] = r.t; cr = r.r;
            @(negedge clk);
            chk($sformatf("row%0d_grant_valid", k), 32'(gv), r.egv ? 32'(1 << r.inp) : 32'd0);
            if (r.egv) chk($sformatf("row%0d_grant_port", k), 32'(gp[r.inp]), 32'(r.egp));
            chk($sformatf("row%0d_flit_send", k), 32'(snd), r.esnd ? 32'(1 << r.inp) : 32'd0);
            chk($sformatf("row%0d_out_busy", k), 32'(busy), 32'(r.ebusy));
            @(posedge clk); #1;
        end
    endtask

    task automatic rr_test();
        int start [N];
        int sent  [N];
        bit last_send, done;
        int c, nown;
        for (int i = 0; i < N; i++) begin start[i] = -1; sent[i] = 0; end
        last_send = 0; done = 0; c = 0;
        while (!done && c < 40) begin
            clear_inputs();
            if (c == 0) sel = 5'b11010;
            for (int i = 1; i < N; i++) begin
                if (i != 2) begin
                    cnt[i] = 2'd1; dir[i][0] = 2'd3;
                    fv[i] = (c > 0) && (sent[i] < 3);
                    tl[i] = (sent[i] == 2);
                end
            end
            cr[4] = last_send;
            @(negedge clk);
            last_send = 0; nown = 0;
            for (int i = 0; i < N; i++) begin
                if (gv[i] && gp[i] == 3'd4) nown++;
                if (gv[i] && start[i] < 0) start[i] = c;
                if (snd[i]) begin sent[i]++; last_send = 1; end
            end
            chk("rr_single_owner", 32'(nown <= 1), 32'd1);
            done = (sent[1] == 3) && (sent[3] == 3) && (sent[4] == 3);
            @(posedge clk); #1;
            c++;
        end
        chk("rr_all_packets_done", 32'(done), 32'd1);
        chk("rr_grant_cycle_in1", 32'(start[1]), 32'd2);
        chk("rr_grant_cycle_in3", 32'(start[3]), 32'd6);
        chk("rr_grant_cycle_in4", 32'(start[4]), 32'd10);

        // pointer now at 4: next contest for output 4 between inputs 0 and 2 goes to 0 first
        clear_inputs();
        sel = 5'b00101; cnt[0] = 2'd1; cnt[2] = 2'd1; dir[0][0] = 2'd3; dir[2][0] = 2'd3;
        fv = 5'b00101; tl = 5'b00101;
        @(posedge clk); #1;
        sel = '0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("ptr_first_winner", 32'(gv), 32'b00001);
        chk("ptr_first_port", 32'(gp[0]), 32'd4);
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("ptr_second_winner", 32'(gv), 32'b00100);
        @(posedge clk); #1;
        clear_inputs();
        @(posedge clk); #1;
    endtask

    task automatic reset_test();
        int nsend;
        clear_inputs();
        sel[2] = 1'b1; cnt[2] = 2'd1; dir[2][0] = 2'd1; fv[2] = 1'b1;
        @(posedge clk); #1;
        sel = '0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_pre_active", 32'(gv), 32'b00100);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        sel[2] = 1'b1;
        @(negedge clk);
        chk("rst_grant_valid", 32'(gv), 32'd0);
        chk("rst_out_busy", 32'(busy), 32'd0);
        chk("rst_flit_send", 32'(snd), 32'd0);
        @(posedge clk); #1;
        sel = '0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_regrant_valid", 32'(gv), 32'b00100);
        chk("rst_regrant_port", 32'(gp[2]), 32'd2);
        nsend = 0;
        for (int c = 0; c < 5; c++) begin
            if (c > 0) @(negedge clk);
            if (snd[2]) nsend++;
            @(posedge clk); #1;
        end
        chk("rst_credits_restored", 32'(nsend), 32'd4);
    endtask

    task automatic random_test(input int cycles);
        reset = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        for (int c = 0; c < cycles; c++) begin
            for (int i = 0; i < N; i++) begin
                sel[i]    = ($urandom_range(0, 9) < 3);
                ej[i]     = ($urandom_range(0, 9) < 2);
                cnt[i]    = 2'($urandom_range(1, 2));
                dir[i][0] = 2'($urandom_range(0, 3));
                dir[i][1] = 2'($urandom_range(0, 3));
                fv[i]     = ($urandom_range(0, 9) < 7);
                tl[i]     = ($urandom_range(0, 9) < 4);
                cr[i]     = (m_cred[i] < DEPTH) && ($urandom_range(0, 2) == 0);
            end
            @(negedge clk);
            model_check();
            model_step();
            @(posedge clk); #1;
        end
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("reset_grant_valid", 32'(gv), 32'd0);
        chk("reset_grant_port", 32'(gp), 32'd0);
        chk("reset_flit_send", 32'(snd), 32'd0);
        chk("reset_out_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // single-flit packet east from input 0
        tbl.push_back(row_strobe(0, 0, 1, 1, 0, 1, 1));
        tbl.push_back(row_idle(0, 5'b0));
        tbl.push_back(row_act(0, 1, 1, 5'b0, 2, 1));
        tbl.push_back(row_idle(0, 5'b0));
        // 3-flit packet north with a bubble; leaves credit[1]=1
        tbl.push_back(row_strobe(0, 0, 1, 0, 0, 1, 0));
        tbl.push_back(row_idle(0, 5'b0));
        tbl.push_back(row_act(0, 1, 0, 5'b0, 1, 1));
        tbl.push_back(row_act(0, 0, 0, 5'b0, 1, 0));
        tbl.push_back(row_act(0, 1, 0, 5'b0, 1, 1));
        tbl.push_back(row_act(0, 1, 1, 5'b0, 1, 1));
        tbl.push_back(row_idle(0, 5'b0));
        // two candidates: credit[1]=1 < credit[2]=3 picks east, then 2/2 tie picks north
        tbl.push_back(row_strobe(1, 0, 2, 0, 1, 1, 1));
        tbl.push_back(row_idle(1, 5'b0));
        tbl.push_back(row_act(1, 1, 1, 5'b0, 2, 1));
        tbl.push_back(row_idle(1, 5'b00010));
        tbl.push_back(row_strobe(1, 0, 2, 0, 1, 1, 1));
        tbl.push_back(row_idle(1, 5'b0));
        tbl.push_back(row_act(1, 1, 1, 5'b0, 1, 1));
        tbl.push_back(row_idle(1, 5'b0));
        // 6-flit packet south: 4 credits, stall, trickle returns
        tbl.push_back(row_strobe(2, 0, 1, 2, 0, 1, 0));
        tbl.push_back(row_idle(2, 5'b0));
        for (int k = 0; k < 4; k++) tbl.push_back(row_act(2, 1, 0, 5'b0, 3, 1));
        tbl.push_back(row_act(2, 1, 0, 5'b0, 3, 0));
        tbl.push_back(row_act(2, 1, 0, 5'b01000, 3, 0));
        tbl.push_back(row_act(2, 1, 0, 5'b0, 3, 1));
        tbl.push_back(row_act(2, 1, 1, 5'b01000, 3, 0));
        tbl.push_back(row_act(2, 1, 1, 5'b0, 3, 1));
        tbl.push_back(row_idle(2, 5'b01000));
        tbl.push_back(row_idle(2, 5'b01000));
        // send plus return in one cycle at credit 2 leaves 2
        tbl.push_back(row_strobe(2, 0, 1, 2, 0, 1, 0));
        tbl.push_back(row_idle(2, 5'b0));
        tbl.push_back(row_act(2, 1, 0, 5'b01000, 3, 1));
        tbl.push_back(row_act(2, 1, 0, 5'b0, 3, 1));
        tbl.push_back(row_act(2, 1, 0, 5'b0, 3, 1));
        tbl.push_back(row_act(2, 1, 1, 5'b0, 3, 0));
        tbl.push_back(row_act(2, 1, 1, 5'b01000, 3, 0));
        tbl.push_back(row_act(2, 1, 1, 5'b0, 3, 1));
        tbl.push_back(row_idle(2, 5'b0));
        // return at full credit saturates; eject packet then sees exactly 4 credits
        tbl.push_back(row_idle(4, 5'b00001));
        tbl.push_back(row_strobe(4, 1, 1, 3, 0, 1, 0));
        tbl.push_back(row_idle(4, 5'b0));
        for (int k = 0; k < 4; k++) tbl.push_back(row_act(4, 1, 0, 5'b0, 0, 1));
        tbl.push_back(row_act(4, 1, 0, 5'b00001, 0, 0));
        tbl.push_back(row_act(4, 1, 1, 5'b0, 0, 1));
        tbl.push_back(row_idle(4, 5'b0));

        run_table();
        rr_test();
        reset_test();
        random_test(3000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule
